fir_output_formatter: RTL
=========================

// Module: fir_output_formatter
// PURPOSE
//  Consumer end of the FIR filter's output stream. Accepts the 32-bit signed accumulator
//  word plus a valid strobe, then removes the filter's coefficient gain by arithmetic shift.
//  Rounds and saturates the result to the 16-bit sample width.
//  Buffers the samples in a small FIFO and presents them on a valid/ready stream to
//  downstream logic (DAC/serialiser). Sticky status flags report saturation and drops.
// PARAMETERS
//  IN_W    32  accumulator (input) width, signed
//  OUT_W   16  output sample width, signed
//  SHIFT   7   gain-removal right shift (8 taps x coef 16 = 128 = 2^7); range 1..IN_W-OUT_W
//  ROUND   1   1: round half-up (add 2^(SHIFT-1) before shift); 0: truncate (floor)
//  DEPTH   4   FIFO depth in words; power of two, >= 2
// PORTS
//  CLK          in   1                  rising-edge clock
//  RST_N        in   1                  asynchronous, active-low reset
//  IN_VALID     in   1                  IN_DATA is valid this cycle (FIR ENABLE delayed 1 clk)
//  IN_DATA      in   IN_W               signed FIR accumulator value
//  OUT_READY    in   1                  downstream accepts OUT_DATA this cycle
//  OUT_VALID    out  1                  OUT_DATA holds a valid sample (= FIFO not empty)
//  OUT_DATA     out  OUT_W              signed scaled sample, head of FIFO
//  COUNT        out  $clog2(DEPTH)+1    FIFO occupancy, 0..DEPTH
//  CLEAR_FLAGS  in   1                  synchronous clear of the sticky flags
//  SAT_FLAG     out  1                  sticky: a sample was clipped
//  OVF_FLAG     out  1                  sticky: a sample was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (RST_N=0, async): FIFO is empty, stage register is invalid, OUT_VALID=0,
//   OUT_DATA=0, COUNT=0, SAT_FLAG=0, OVF_FLAG=0. Reset mid-stream discards all data.
//  Stage 1 (registered): at each edge with IN_VALID=1,
//   t = sext(IN_DATA, IN_W+1) + (ROUND ? 2^(SHIFT-1) : 0).
//   s = t >>> SHIFT. The extra bit means rounding never wraps.
//   If s > 2^(OUT_W-1)-1, clip to max. If s < -2^(OUT_W-1), clip to min.
//   The clip raises a saturation event. The stage valid bit is loaded with IN_VALID every edge.
//  Stage 2: when the stage is valid, the word is pushed into the FIFO on the next edge.
//  Latency: IN_VALID high at edge k -> stage valid after k -> OUT_VALID/OUT_DATA after
//   edge k+1, when the FIFO was empty (first-word fall-through).
//  Handshake: a pop occurs on an edge with OUT_VALID & OUT_READY. OUT_DATA is stable
//   while OUT_VALID=1 and OUT_READY=0. OUT_READY while empty is ignored.
//  Full: a push when COUNT==DEPTH and there is no pop that edge drops the word.
//   OVF_FLAG is set and the FIFO contents are unchanged.
//   A push and a pop on the same edge at full are both performed; COUNT stays DEPTH.
//  Empty: a push and a pop on the same edge at empty cannot occur (OUT_VALID=0). The push
//   lands and OUT_VALID rises after that edge.
//  Pointers wrap modulo DEPTH. COUNT = wr-rd, using pointers one bit wider than the address.
//  Flags: set on event, cleared by CLEAR_FLAGS. An event and a clear on the same edge -> flag
//   is set (event wins).
//  Input back-pressure does not exist: IN_VALID is never stalled, and overflow is signalled
//   only via OVF_FLAG.
// STRUCTURE
//  fir_pkg: FIR_IN_W=32, FIR_OUT_W=16, FIR_GAIN_SHIFT=7, FIR_NTAPS=8 shared with
//   fir_filter; a constant function clog2 when the tool lacks $clog2.
//  Sub-module sync_fifo_fwft (DEPTH, WIDTH): push/pop/full/empty/count, registered pointers.
//   Scaling/saturation stays inline in this module.
// TESTING (defaults)
//  1 Scale: IN_DATA=12800 then -12800 -> OUT_DATA=100 then -100. OUT_VALID occurs 2 clks
//    after IN_VALID. SAT_FLAG=0.
//  2 Rounding: IN_DATA=64 -> 1; IN_DATA=-64 -> 0; IN_DATA=63 -> 0.
//    With ROUND=0: IN_DATA=64 -> 0, IN_DATA=-1 -> -1.
//  3 Saturation: 0x7FFFFFFF -> 32767 and SAT_FLAG=1. 0x80000000 -> -32768.
//    CLEAR_FLAGS pulse -> SAT_FLAG=0.
//  4 Overflow: OUT_READY=0, push 1..5 -> COUNT=4, OVF_FLAG=1.
//    Then OUT_READY=1 -> drains 1,2,3,4 in order; COUNT=0; OUT_VALID=0.
//  5 Full with simultaneous push and pop: FIFO holds 4, push 9 with OUT_READY=1 -> pops 1,
//    COUNT stays 4, OVF_FLAG unchanged, 9 appears last.
//  6 Reset mid-stream: RST_N low for half a cycle with COUNT=3 -> all outputs 0 immediately.
//    The first sample after release appears with the normal 2-clk latency.

Source files
------------

// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
//  Constants shared between the FIR filter and its output formatter, plus a
//  constant log2 helper usable where $clog2 is unavailable.
//  FIR_GAIN_SHIFT is derived from the filter's total coefficient gain
//  (taps x coefficient = 8 x 16 = 128 = 2^7).
// ----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_IN_W      = 32;
  localparam int FIR_OUT_W     = 16;
  localparam int FIR_NTAPS     = 8;
  localparam int FIR_COEF_GAIN = 16;

  // Smallest r with 2^r >= value (value >= 1).
  function automatic int fir_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int FIR_GAIN_SHIFT = fir_clog2(FIR_NTAPS * FIR_COEF_GAIN);

endpackage

// File: rtl/sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
//  Single-clock first-word-fall-through FIFO. The head word is visible on
//  RD_DATA whenever EMPTY=0. Pointers are one bit wider than the address so
//  that COUNT = wr - rd distinguishes full from empty.
//  Ports:
//   CLK, RST_N   clock, asynchronous active-low reset
//   PUSH/WR_DATA write request and data (ignored when full unless popping)
//   POP          read request (ignored when empty)
//   RD_DATA      head of FIFO
//   FULL, EMPTY  status
//   COUNT        occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo_fwft
  import fir_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        PUSH,
  input  logic [WIDTH-1:0]            WR_DATA,
  input  logic                        POP,
  output logic [WIDTH-1:0]            RD_DATA,
  output logic                        FULL,
  output logic                        EMPTY,
  output logic [fir_clog2(DEPTH):0]   COUNT
);

  localparam int AW = fir_clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      count_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Occupancy, status and qualified push/pop. A push at full is accepted
  // only when a pop frees the head slot on the same edge.
  always_comb begin
    count_s   = wr_ptr_r - rd_ptr_r;
    EMPTY     = (count_s == {(AW+1){1'b0}});
    FULL      = (count_s == DEPTH_C);
    do_pop_s  = POP & ~EMPTY;
    do_push_s = PUSH & (~FULL | do_pop_s);
    COUNT     = count_s;
    RD_DATA   = mem_r[rd_ptr_r[AW-1:0]];
  end

  // Pointer and storage update.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= WR_DATA;
        wr_ptr_r                <= wr_ptr_r + ONE_C;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: rtl/fir_output_formatter.sv
// ----------------------------------------------------------------------------
// fir_output_formatter
//  Consumer end of the FIR output stream: removes the coefficient gain with an
//  arithmetic right shift (optionally rounding half-up), saturates to OUT_W,
//  buffers samples in a FWFT FIFO and presents them on a valid/ready stream.
//  Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   IN_VALID, IN_DATA   accumulator word (never stalled)
//   OUT_READY           downstream accepts OUT_DATA
//   OUT_VALID, OUT_DATA head of FIFO (OUT_DATA=0 while empty)
//   COUNT               FIFO occupancy 0..DEPTH
//   CLEAR_FLAGS         synchronous clear of the sticky flags
//   SAT_FLAG            sticky: a sample was clipped
//   OVF_FLAG            sticky: a sample was dropped on a full FIFO
// ----------------------------------------------------------------------------
module fir_output_formatter
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_IN_W,
  parameter int OUT_W = FIR_OUT_W,
  parameter int SHIFT = FIR_GAIN_SHIFT,
  parameter int ROUND = 1,
  parameter int DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      IN_VALID,
  input  logic [IN_W-1:0]           IN_DATA,
  input  logic                      OUT_READY,
  output logic                      OUT_VALID,
  output logic [OUT_W-1:0]          OUT_DATA,
  output logic [fir_clog2(DEPTH):0] COUNT,
  input  logic                      CLEAR_FLAGS,
  output logic                      SAT_FLAG,
  output logic                      OVF_FLAG
);

  // One extra bit of headroom so the rounding offset can never wrap.
  localparam logic signed [IN_W:0] ONE_C = {{IN_W{1'b0}}, 1'b1};
  localparam logic signed [IN_W:0] RND_C = (ROUND != 0) ? (ONE_C <<< (SHIFT - 1))
                                                        : {(IN_W+1){1'b0}};
  localparam logic signed [IN_W:0] MAX_C = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_C = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0]  ext_s;
  logic signed [IN_W:0]  t_s;
  logic signed [IN_W:0]  s_s;
  logic [OUT_W-1:0]      sample_s;
  logic                  sat_s;

  logic                  stage_valid_r;
  logic [OUT_W-1:0]      stage_data_r;
  logic                  sat_flag_r;
  logic                  ovf_flag_r;

  logic [OUT_W-1:0]      fifo_rd_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  pop_s;
  logic                  ovf_evt_s;

  // Gain removal, rounding and clipping of the incoming accumulator word.
  always_comb begin
    ext_s = {IN_DATA[IN_W-1], IN_DATA};
    t_s   = ext_s + RND_C;
    s_s   = t_s >>> SHIFT;
    if (s_s > MAX_C) begin
      sample_s = MAX_C[OUT_W-1:0];
      sat_s    = 1'b1;
    end else if (s_s < MIN_C) begin
      sample_s = MIN_C[OUT_W-1:0];
      sat_s    = 1'b1;
    end else begin
      sample_s = s_s[OUT_W-1:0];
      sat_s    = 1'b0;
    end
  end

  // Stage register between the scaler and the FIFO write port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage_valid_r <= 1'b0;
      stage_data_r  <= {OUT_W{1'b0}};
    end else begin
      stage_valid_r <= IN_VALID;
      if (IN_VALID) begin
        stage_data_r <= sample_s;
      end else begin
        stage_data_r <= stage_data_r;
      end
    end
  end

  // A pop only happens while data is present; a staged word is dropped when
  // the FIFO is full and nothing leaves on the same edge.
  assign pop_s     = OUT_READY & ~fifo_empty_s;
  assign ovf_evt_s = stage_valid_r & fifo_full_s & ~pop_s;

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .PUSH    (stage_valid_r),
    .WR_DATA (stage_data_r),
    .POP     (pop_s),
    .RD_DATA (fifo_rd_s),
    .FULL    (fifo_full_s),
    .EMPTY   (fifo_empty_s),
    .COUNT   (COUNT)
  );

  // Sticky flags; a new event takes priority over a clear on the same edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sat_flag_r <= 1'b0;
      ovf_flag_r <= 1'b0;
    end else begin
      if (IN_VALID & sat_s) begin
        sat_flag_r <= 1'b1;
      end else if (CLEAR_FLAGS) begin
        sat_flag_r <= 1'b0;
      end else begin
        sat_flag_r <= sat_flag_r;
      end
      if (ovf_evt_s) begin
        ovf_flag_r <= 1'b1;
      end else if (CLEAR_FLAGS) begin
        ovf_flag_r <= 1'b0;
      end else begin
        ovf_flag_r <= ovf_flag_r;
      end
    end
  end

  assign OUT_VALID = ~fifo_empty_s;
  assign OUT_DATA  = fifo_empty_s ? {OUT_W{1'b0}} : fifo_rd_s;
  assign SAT_FLAG  = sat_flag_r;
  assign OVF_FLAG  = ovf_flag_r;

endmodule
